// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned ADJ_THRESHOLD = 5;
    localparam int unsigned ADJ_ADD       = 3;

    // Decimal digits needed for 2^width-1: floor(width*log10(2)) + 1.
    function automatic int unsigned bcd_digits_for(input int unsigned width);
        return (width * 32'd30103) / 32'd100000 + 32'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted_c
);

    assign adjusted_c = (digit >= BCD_DIGIT_W'(ADJ_THRESHOLD))
                      ? digit + BCD_DIGIT_W'(ADJ_ADD)
                      : digit;

endmodule

// File: rtl/bcd_serial_converter.sv
// Multi-cycle binary to packed-BCD converter, one double-dabble step per clock.
// Optional BCD_SERIAL_CONVERTER_BLANK_EN adds a leading-zero blanking output.
module bcd_serial_converter
    import bcd_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned DIGITS   = 5,
    parameter int unsigned CNT_W    = $clog2(IN_WIDTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_WIDTH-1:0]           binary,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
`ifdef BCD_SERIAL_CONVERTER_BLANK_EN
    ,
    output logic [DIGITS-1:0]             blank
`endif
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0]    bcd_d;
    logic [BCD_W-1:0]    adj_c;
    logic                overflow_d;
    logic                out_valid_d;
    logic                in_ready_d;
    logic                carry_c;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit      (bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted_c (adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd;
        overflow_d  = overflow;
        out_valid_d = out_valid;
        carry_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_d    = binary;
                    bcd_d      = '0;
                    overflow_d = 1'b0;
                    cnt_d      = CNT_W'(IN_WIDTH);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {carry_c, bcd_d} = {adj_c, shreg_q[IN_WIDTH-1]};
                overflow_d       = overflow | carry_c;
                shreg_d          = shreg_q << 1;
                cnt_d            = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

`ifdef BCD_SERIAL_CONVERTER_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic              zero_above;

    // A digit blanks only if it and all higher digits are zero; digit 0 always shows
    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above & (bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_d[i] = zero_above;
        end
        blank_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank <= '0;
        end else begin
            blank <= blank_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            bcd       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            bcd       <= bcd_d;
            overflow  <= overflow_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule
